// File: rtl/spike_scheduler_if.sv
// Event push channel for spike_scheduler: (time,row) events offered over valid/ready.
// The producer uses the master modport and the scheduler uses the slave modport.
interface spike_scheduler_if #(
    parameter int TIME_WIDTH = 16,
    parameter int ROW_WIDTH  = 1
);
    logic                  evt_valid;
    logic                  evt_ready;
    logic [TIME_WIDTH-1:0] evt_time;
    logic [ROW_WIDTH-1:0]  evt_row;

    modport master (
        output evt_valid,
        output evt_time,
        output evt_row,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_time,
        input  evt_row,
        output evt_ready
    );
endinterface

// File: rtl/spike_scheduler.sv
// spike_scheduler: buffers timestamped (time,row) events in a FIFO and emits a
// one-cycle pulse on spike_out_o[row] when the logical time counter reaches the
// event timestamp. Late heads are dropped and counted; sys_time stalls while
// due or late entries drain so equal-timestamp events leave back to back.
// Optional build macro: SPIKE_SCHED_STATS_EN adds emit_cnt_o, a wrapping count
// of pulses emitted.
module spike_scheduler #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int TIME_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 8,
    parameter int ROW_WIDTH        = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable_i,
    spike_scheduler_if.slave            evt_if,
    output logic [NUM_SYNAPSE_ROWS-1:0] spike_out_o,
    output logic [TIME_WIDTH-1:0]       sys_time_o,
    output logic                        busy_o,
    output logic [7:0]                  late_cnt_o
`ifdef SPIKE_SCHED_STATS_EN
    ,
    output logic [31:0]                 emit_cnt_o
`endif
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    // Event storage; flushed logically by resetting the pointers and count.
    logic [TIME_WIDTH-1:0]       time_mem_q [FIFO_DEPTH];
    logic [ROW_WIDTH-1:0]        row_mem_q  [FIFO_DEPTH];

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]              count_q,  count_d;
    logic [TIME_WIDTH-1:0]       sys_time_q, sys_time_d;
    logic [NUM_SYNAPSE_ROWS-1:0] spike_q,  spike_d;
    logic [7:0]                  late_cnt_q, late_cnt_d;
    logic                        busy_q;
    logic                        ready_q;

    logic [TIME_WIDTH-1:0]       head_time_s;
    logic [ROW_WIDTH-1:0]        head_row_s;
    logic [TIME_WIDTH-1:0]       diff_s;
    logic                        head_due_s;
    logic                        head_late_s;
    logic                        pop_s;
    logic                        push_s;

    // Classify the head entry against the current logical time (modular distance).
    always_comb begin
        head_time_s = time_mem_q[rd_ptr_q];
        head_row_s  = row_mem_q[rd_ptr_q];
        diff_s      = head_time_s - sys_time_q;
        head_due_s  = busy_q && (diff_s == {TIME_WIDTH{1'b0}});
        head_late_s = busy_q && diff_s[TIME_WIDTH-1];
        pop_s       = head_due_s || head_late_s;
        push_s      = evt_if.evt_valid && ready_q;
    end

    // Next-state for pointers, occupancy, time, pulses and the late counter.
    always_comb begin
        spike_d = {NUM_SYNAPSE_ROWS{1'b0}};
        // Out-of-range rows match no bit, so they pop silently.
        for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            spike_d[r] = head_due_s && (head_row_s == ROW_WIDTH'(r));
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // Time holds while an entry drains so same-timestamp events share it.
        if (enable_i && !pop_s) begin
            sys_time_d = sys_time_q + TIME_WIDTH'(1);
        end else begin
            sys_time_d = sys_time_q;
        end

        if (head_late_s && (late_cnt_q != 8'hFF)) begin
            late_cnt_d = late_cnt_q + 8'd1;
        end else begin
            late_cnt_d = late_cnt_q;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {(PTR_W + 1){1'b0}};
            sys_time_q <= {TIME_WIDTH{1'b0}};
            spike_q    <= {NUM_SYNAPSE_ROWS{1'b0}};
            late_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sys_time_q <= sys_time_d;
            spike_q    <= spike_d;
            late_cnt_q <= late_cnt_d;
            busy_q     <= (count_d != {(PTR_W + 1){1'b0}});
            ready_q    <= (count_d != DEPTH_C);
        end
    end

    // Event payload write at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            time_mem_q[wr_ptr_q] <= evt_if.evt_time;
            row_mem_q[wr_ptr_q]  <= evt_if.evt_row;
        end else begin
            time_mem_q[wr_ptr_q] <= time_mem_q[wr_ptr_q];
            row_mem_q[wr_ptr_q]  <= row_mem_q[wr_ptr_q];
        end
    end

`ifdef SPIKE_SCHED_STATS_EN
    logic [31:0] emit_cnt_q;

    // Count pulses actually driven onto spike_out (late and out-of-range excluded).
    always_ff @(posedge clk) begin
        if (!reset) begin
            emit_cnt_q <= 32'd0;
        end else if (spike_d != {NUM_SYNAPSE_ROWS{1'b0}}) begin
            emit_cnt_q <= emit_cnt_q + 32'd1;
        end else begin
            emit_cnt_q <= emit_cnt_q;
        end
    end

    assign emit_cnt_o = emit_cnt_q;
`else
    // Statistics counter not built.
`endif

    assign evt_if.evt_ready = ready_q;
    assign spike_out_o      = spike_q;
    assign sys_time_o       = sys_time_q;
    assign busy_o           = busy_q;
    assign late_cnt_o       = late_cnt_q;

endmodule

// File: tb/tb_spike_scheduler.sv
// Bench for spike_scheduler: instance A (16-bit time) and instance B (4-bit time)
// are compared every cycle against a queue-based reference model, with directed
// scenarios adding literal expectations.
module tb_spike_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        en_a  = 1'b0, en_b  = 1'b0;
    logic [1:0]  spike_a, spike_b;
    logic [15:0] st_a;
    logic [3:0]  st_b;
    logic        busy_a, busy_b;
    logic [7:0]  late_a, late_b;
`ifdef SPIKE_SCHED_STATS_EN
    logic [31:0] emit_a, emit_b;
`endif

    spike_scheduler_if #(.TIME_WIDTH(16), .ROW_WIDTH(1)) if_a ();
    spike_scheduler_if #(.TIME_WIDTH(4),  .ROW_WIDTH(1)) if_b ();

    spike_scheduler #(.NUM_SYNAPSE_ROWS(2), .TIME_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .reset(rst_a), .enable_i(en_a), .evt_if(if_a.slave),
        .spike_out_o(spike_a), .sys_time_o(st_a), .busy_o(busy_a), .late_cnt_o(late_a)
`ifdef SPIKE_SCHED_STATS_EN
        , .emit_cnt_o(emit_a)
`endif
    );

    spike_scheduler #(.NUM_SYNAPSE_ROWS(2), .TIME_WIDTH(4), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .reset(rst_b), .enable_i(en_b), .evt_if(if_b.slave),
        .spike_out_o(spike_b), .sys_time_o(st_b), .busy_o(busy_b), .late_cnt_o(late_b)
`ifdef SPIKE_SCHED_STATS_EN
        , .emit_cnt_o(emit_b)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int st[2], lc[2], ec[2], sz[2], hd[2];
    int qt[2][8], qr[2][8];
    int e_spk[2];
    int mask[2] = '{32'hFFFF, 32'hF};
    bit mv[2]   = '{1'b0, 1'b0};

    task automatic model_step(input int k, input bit rs, input bit en, input bit vl,
                              input int t, input int r);
        bit popped;
        bit push_ok;
        int d;
        if (!rs) begin
            sz[k] = 0; hd[k] = 0; st[k] = 0; lc[k] = 0; ec[k] = 0; e_spk[k] = 0; mv[k] = 1'b1;
            return;
        end
        e_spk[k] = 0;
        popped   = 1'b0;
        if (sz[k] > 0) begin
            d = (qt[k][hd[k]] - st[k]) & mask[k];
            if (d == 0) begin
                popped = 1'b1;
                if (qr[k][hd[k]] < 2) begin
                    e_spk[k] = 1 << qr[k][hd[k]];
                    ec[k]++;
                end
            end else if (d > (mask[k] >> 1)) begin
                popped = 1'b1;
                if (lc[k] < 255) lc[k]++;
            end
        end
        push_ok = vl && (sz[k] < 8);
        if (popped) begin
            hd[k] = (hd[k] + 1) % 8;
            sz[k]--;
        end
        if (en && !popped) st[k] = (st[k] + 1) & mask[k];
        if (push_ok) begin
            qt[k][(hd[k] + sz[k]) % 8] = t;
            qr[k][(hd[k] + sz[k]) % 8] = r;
            sz[k]++;
        end
    endtask

    // Model advances on the same edge as the DUTs, using the inputs held since negedge.
    always @(posedge clk) begin
        model_step(0, rst_a, en_a, if_a.evt_valid, int'(if_a.evt_time), int'(if_a.evt_row));
        model_step(1, rst_b, en_b, if_b.evt_valid, int'(if_b.evt_time), int'(if_b.evt_row));
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (mv[0]) begin
            cmp("a_spike", 32'(spike_a), e_spk[0]);
            cmp("a_sys_time", 32'(st_a), st[0]);
            cmp("a_busy", 32'(busy_a), 32'(sz[0] > 0));
            cmp("a_ready", 32'(if_a.evt_ready), 32'(sz[0] < 8));
            cmp("a_late_cnt", 32'(late_a), lc[0]);
`ifdef SPIKE_SCHED_STATS_EN
            cmp("a_emit_cnt", emit_a, ec[0]);
`endif
        end
        if (mv[1]) begin
            cmp("b_spike", 32'(spike_b), e_spk[1]);
            cmp("b_sys_time", 32'(st_b), st[1]);
            cmp("b_busy", 32'(busy_b), 32'(sz[1] > 0));
            cmp("b_ready", 32'(if_b.evt_ready), 32'(sz[1] < 8));
            cmp("b_late_cnt", 32'(late_b), lc[1]);
`ifdef SPIKE_SCHED_STATS_EN
            cmp("b_emit_cnt", emit_b, ec[1]);
`endif
        end
    end

    task automatic wait_spike(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((k == 0 && spike_a != 2'b00) || (k == 1 && spike_b != 2'b00)) begin
                ok = 1'b1;
                return;
            end
        end
        cmp("spike_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_a(input int t, input int r);
        if_a.evt_valid = 1'b1;
        if_a.evt_time  = 16'(t);
        if_a.evt_row   = 1'(r);
        @(negedge clk);
        if_a.evt_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int spikes;
        int last_t;
`ifdef SPIKE_SCHED_STATS_EN
        logic [31:0] e0;
`endif
        if_a.evt_valid = 1'b0; if_a.evt_time = 16'd0; if_a.evt_row = 1'b0;
        if_b.evt_valid = 1'b0; if_b.evt_time = 4'd0;  if_b.evt_row = 1'b0;

        // Scenario 1: reset, push (5,1)
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        cmp("s1_rst_sys_time", 32'(st_a), 32'd0);
        cmp("s1_rst_spike", 32'(spike_a), 32'd0);
        cmp("s1_rst_busy", 32'(busy_a), 32'd0);
        cmp("s1_rst_ready", 32'(if_a.evt_ready), 32'd1);
        rst_a = 1'b1;
        push_a(5, 1);
        wait_spike(0, 50, ok);
        if (ok) begin
            cmp("s1_spike", 32'(spike_a), 32'h2);
            cmp("s1_sys_time", 32'(st_a), 32'd5);
        end
        @(negedge clk);
        cmp("s1_spike_off", 32'(spike_a), 32'd0);
        cmp("s1_busy_off", 32'(busy_a), 32'd0);

        // Scenario 2: (10,0),(10,1),(12,0)
`ifdef SPIKE_SCHED_STATS_EN
        e0 = emit_a;
`endif
        en_a = 1'b0;
        push_a(10, 0);
        push_a(10, 1);
        push_a(12, 0);
        en_a = 1'b1;
        wait_spike(0, 50, ok);
        if (ok) begin
            cmp("s2_first", 32'(spike_a), 32'h1);
            cmp("s2_first_t", 32'(st_a), 32'd10);
            @(negedge clk);
            cmp("s2_second", 32'(spike_a), 32'h2);
            cmp("s2_second_t", 32'(st_a), 32'd10);
        end
        wait_spike(0, 50, ok);
        if (ok) begin
            cmp("s2_third", 32'(spike_a), 32'h1);
            cmp("s2_third_t", 32'(st_a), 32'd12);
        end
`ifdef SPIKE_SCHED_STATS_EN
        cmp("s2_emit_delta", emit_a - e0, 32'd3);
`endif

        // Scenario 3: late events and saturation
        for (int i = 0; i < 100 && st_a < 16'd20; i++) @(negedge clk);
        cmp("s3_late_before", 32'(late_a), 32'd0);
        push_a(15, 0);
        repeat (2) @(negedge clk);
        cmp("s3_late_one", 32'(late_a), 32'd1);
        cmp("s3_busy", 32'(busy_a), 32'd0);
        if_a.evt_valid = 1'b1; if_a.evt_time = 16'd15; if_a.evt_row = 1'b0;
        repeat (300) @(negedge clk);
        if_a.evt_valid = 1'b0;
        repeat (3) @(negedge clk);
        cmp("s3_late_sat", 32'(late_a), 32'd255);

        // Scenario 4: fill with enable low, then drain
        en_a = 1'b0;
        for (int i = 0; i < 8; i++) push_a(100, 0);
        cmp("s4_full", 32'(if_a.evt_ready), 32'd0);
        en_a = 1'b1;
        wait_spike(0, 200, ok);
        if (ok) begin
            cmp("s4_ready_back", 32'(if_a.evt_ready), 32'd1);
            spikes = 0;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clk);
                if (spike_a == 2'b01 && st_a == 16'd100) spikes++;
            end
            cmp("s4_pulses", 32'(spikes), 32'd8);
        end

        // Scenario 6: reset with queued events
        en_a = 1'b0;
        push_a(int'(st_a) + 50, 0);
        push_a(int'(st_a) + 51, 1);
        push_a(int'(st_a) + 52, 0);
        rst_a = 1'b0;
        @(negedge clk);
        cmp("s6_busy", 32'(busy_a), 32'd0);
        cmp("s6_sys_time", 32'(st_a), 32'd0);
        rst_a = 1'b1; en_a = 1'b1;
        spikes = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (spike_a != 2'b00) spikes++;
        end
        cmp("s6_no_pulses", 32'(spikes), 32'd0);

        // Scenario 5: 4-bit time wrap on instance B
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1; en_b = 1'b1;
        for (int i = 0; i < 40 && st_b != 4'd14; i++) @(negedge clk);
        cmp("s5_at14", 32'(st_b), 32'd14);
        if_b.evt_valid = 1'b1; if_b.evt_time = 4'd2; if_b.evt_row = 1'b0;
        @(negedge clk);
        if_b.evt_valid = 1'b0;
        cmp("s5_at15", 32'(st_b), 32'd15);
        wait_spike(1, 20, ok);
        if (ok) begin
            cmp("s5_spike", 32'(spike_b), 32'h1);
            cmp("s5_sys_time", 32'(st_b), 32'd2);
            cmp("s5_late", 32'(late_b), 32'd0);
        end

        // Random traffic on both instances, checked by the model every cycle
        last_t = int'(st_a) + 4;
        for (int c = 0; c < 3000; c++) begin
            en_a = ($urandom_range(0, 99) < 80);
            rst_a = ($urandom_range(0, 599) != 0);
            if (!rst_a) last_t = 4;
            if_a.evt_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) begin
                if_a.evt_time = st_a - 16'($urandom_range(1, 10));
            end else begin
                if_a.evt_time = 16'(last_t + $urandom_range(0, 3));
                if (if_a.evt_valid && if_a.evt_ready) last_t = int'(if_a.evt_time);
            end
            if_a.evt_row = 1'($urandom_range(0, 1));
            en_b = ($urandom_range(0, 99) < 70);
            rst_b = ($urandom_range(0, 299) != 0);
            if_b.evt_valid = ($urandom_range(0, 2) == 0);
            if_b.evt_time  = 4'($urandom_range(0, 15));
            if_b.evt_row   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if_a.evt_valid = 1'b0;
        if_b.evt_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
